// File: rtl/seg_message_scroller.sv
// rtl/seg_message_scroller.sv - ASCII message buffer sequenced onto NUM_DIGITS seven-segment digits, static or scrolling (optional blink: SEG_BLINK_EN)
module seg_message_scroller #(
  parameter int NUM_DIGITS = 8,
  parameter int MAX_LEN    = 32,
  parameter int TICK_DIV   = 12_500_000
) (
  input  logic                          Clk,
  input  logic                          Reset,
`ifdef SEG_BLINK_EN
  input  logic                          blink_en,
`endif
  input  logic                          wr_en,
  input  logic [$clog2(MAX_LEN)-1:0]    wr_addr,
  input  logic [6:0]                    wr_char,
  input  logic [$clog2(MAX_LEN):0]      msg_len,
  input  logic                          scroll_en,
  input  logic                          start,
  input  logic                          stop,
  output logic [7*NUM_DIGITS-1:0]       disp_chars,
  output logic                          busy,
  output logic                          wrap
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  // Wide enough for p up to 2*P-2 with P = MAX_LEN + NUM_DIGITS.
  localparam int PW = $clog2(MAX_LEN + NUM_DIGITS) + 1;
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [6:0] BLANK = 7'd32;

  typedef enum logic [1:0] {IDLE, SHOW, SCROLL} state_t;

  state_t              state;
  logic [6:0]          mem [MAX_LEN];
  logic [LW-1:0]       len;
  logic [LW-1:0]       len_clip;
  logic [PW-1:0]       offset;
  logic [PW-1:0]       period;
  logic [PW-1:0]       p;
  logic [PW-1:0]       q;
  logic [CW-1:0]       cnt;
  logic                run_cnt;
  logic                tick;
  logic                start_ok;
  logic                addr_ok;
  logic [7*NUM_DIGITS-1:0] next_disp;
`ifdef SEG_BLINK_EN
  logic                phase;
`endif

  assign period   = PW'(len) + PW'(NUM_DIGITS);
  assign start_ok = start && (msg_len != '0);
  assign len_clip = (msg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : msg_len;
  assign addr_ok  = (int'(wr_addr) < MAX_LEN);
`ifdef SEG_BLINK_EN
  assign run_cnt  = (state == SCROLL) || (state == SHOW);
`else
  assign run_cnt  = (state == SCROLL);
`endif
  assign tick     = run_cnt && (cnt == CW'(TICK_DIV - 1));

  // Message buffer: written in any state, never cleared by Reset.
  always_ff @(posedge Clk) begin
    if (wr_en && addr_ok) mem[wr_addr] <= wr_char;
  end

  // Control FSM: mode/length latch, tick counter, scroll offset and wrap pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      wrap   <= 1'b0;
      len    <= '0;
      offset <= '0;
      cnt    <= '0;
`ifdef SEG_BLINK_EN
      phase  <= 1'b0;
`endif
    end else begin
      wrap <= 1'b0;
      if (stop) begin
        // stop dominates a simultaneous start
        state  <= IDLE;
        busy   <= 1'b0;
        offset <= '0;
        cnt    <= '0;
`ifdef SEG_BLINK_EN
        phase  <= 1'b0;
`endif
      end else if (start_ok) begin
        state  <= scroll_en ? SCROLL : SHOW;
        busy   <= 1'b1;
        len    <= len_clip;
        offset <= '0;
        cnt    <= '0;
`ifdef SEG_BLINK_EN
        phase  <= 1'b0;
`endif
      end else if (run_cnt) begin
        if (tick) begin
          cnt <= '0;
          if (state == SCROLL) begin
            if (offset == period - PW'(1)) begin
              offset <= '0;
              wrap   <= 1'b1;
            end else begin
              offset <= offset + PW'(1);
            end
          end
`ifdef SEG_BLINK_EN
          if (state == SHOW && blink_en) phase <= ~phase;
`endif
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Map each digit to its message position; mod P by a single compare/subtract.
  always_comb begin
    next_disp = {NUM_DIGITS{BLANK}};
    p = '0;
    q = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      p = offset + PW'(NUM_DIGITS - 1 - k);
      q = (state == SCROLL && p >= period) ? p - period : p;
      if (state != IDLE && q < PW'(len)) next_disp[7*k +: 7] = mem[q[AW-1:0]];
    end
`ifdef SEG_BLINK_EN
    if (state == SHOW && blink_en && phase) next_disp = {NUM_DIGITS{BLANK}};
`endif
  end

  // Registered digit codes, one cycle behind state/offset/buffer.
  always_ff @(posedge Clk) begin
    if (Reset) disp_chars <= {NUM_DIGITS{BLANK}};
    else       disp_chars <= next_disp;
  end

endmodule
